// File: rtl/mod_counter.sv
// Modulo up/down counter with load, clear, wrap/saturate mode, terminal-count pulse and sticky
// overflow. Define MOD_COUNTER_PRESCALE_EN to add a prescaler that divides the enable.
module mod_counter #(
    parameter int unsigned       width    = 8,
    parameter longint unsigned   modulo   = 256,
    parameter int unsigned       saturate = 0,
    parameter int unsigned       prescale = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [width-1:0] load_val,
    output logic [width-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam longint unsigned range_size = 64'd1 << width;

    if (width < 1 || width > 32) begin : g_bad_width
        $error("mod_counter: width must be in 1..32");
    end
    if (modulo < 2 || modulo > range_size) begin : g_bad_modulo
        $error("mod_counter: modulo must be in 2..2**width");
    end
    if (prescale < 1) begin : g_bad_prescale
        $error("mod_counter: prescale must be >= 1");
    end

    // Top of range held in width+1 bits so modulo==2**width compares correctly.
    localparam logic [width:0] top_val = (width+1)'(modulo - 64'd1);

    logic [width-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;

`ifdef MOD_COUNTER_PRESCALE_EN
    if (prescale == 1) begin : g_no_ps
        assign tick = en;
    end else begin : g_ps
        localparam int unsigned ps_w = $clog2(prescale);
        localparam logic [ps_w-1:0] ps_last = ps_w'(prescale - 1);

        logic [ps_w-1:0] ps_q, ps_d;

        assign tick = en && (ps_q == ps_last);

        always_comb begin
            ps_d = ps_q;
            if (clr || load) begin
                ps_d = '0;
            end else if (en) begin
                ps_d = tick ? '0 : ps_q + ps_w'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ps_q <= '0;
            end else begin
                ps_q <= ps_d;
            end
        end
    end
`else
    assign tick = en;
`endif

    logic [width:0] cnt_ext;
    logic [width:0] load_ext;
    logic           at_top;
    logic           at_zero;

    assign cnt_ext  = {1'b0, cnt_q};
    assign load_ext = {1'b0, load_val};
    assign at_top   = (cnt_ext == top_val);
    assign at_zero  = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = (load_ext > top_val) ? top_val[width-1:0] : load_val;
        end else if (tick) begin
            if (dir) begin
                if (at_top) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    cnt_d = (saturate != 0) ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + width'(1);
                end
            end else begin
                if (at_zero) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    cnt_d = (saturate != 0) ? cnt_q : top_val[width-1:0];
                end else begin
                    cnt_d = cnt_q - width'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule
